// File: rtl/serial_subtractor.sv
// ============================================================================
//  Module   : serial_subtractor
//  Purpose  : Bit-serial D = A - B (LSB first) with a single full-subtractor
//             cell, valid/ready handshakes, borrow-out and signed overflow.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module serial_subtractor #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ena,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] d,
    output logic             bout,
    output logic             ovf
);

    localparam int               c_CW   = $clog2(WIDTH);
    localparam logic [c_CW-1:0]  c_LAST = c_CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t            r_state;
    logic [WIDTH-1:0]  r_a_sh;
    logic [WIDTH-1:0]  r_b_sh;
    logic [WIDTH-1:0]  r_d_sh;
    logic [c_CW-1:0]   r_cnt;
    logic              r_borrow;
    logic              r_a_msb;
    logic              r_b_msb;
    logic              r_bout;
    logic              r_ovf;

    logic              w_x;
    logic              w_y;
    logic              w_diff;
    logic              w_borrow_nxt;

    assign w_x          = r_a_sh[0];
    assign w_y          = r_b_sh[0];
    assign w_diff       = w_x ^ w_y ^ r_borrow;
    assign w_borrow_nxt = (~w_x & w_y) | (~(w_x ^ w_y) & r_borrow);

    // Handshakes are also masked by reset so nothing completes while held.
    assign in_ready  = rst_n & ena & (r_state == S_IDLE);
    assign out_valid = rst_n & ena & (r_state == S_DONE);

    assign d    = r_d_sh;
    assign bout = r_bout;
    assign ovf  = r_ovf;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state  <= S_IDLE;
            r_a_sh   <= '0;
            r_b_sh   <= '0;
            r_d_sh   <= '0;
            r_cnt    <= '0;
            r_borrow <= 1'b0;
            r_a_msb  <= 1'b0;
            r_b_msb  <= 1'b0;
            r_bout   <= 1'b0;
            r_ovf    <= 1'b0;
        end else if (ena) begin
            case (r_state)
                S_IDLE: begin
                    if (in_valid) begin
                        r_a_sh   <= a;
                        r_b_sh   <= b;
                        r_a_msb  <= a[WIDTH-1];
                        r_b_msb  <= b[WIDTH-1];
                        r_borrow <= 1'b0;
                        r_cnt    <= '0;
                        r_state  <= S_SHIFT;
                    end
                end
                S_SHIFT: begin
                    r_a_sh   <= r_a_sh >> 1;
                    r_b_sh   <= r_b_sh >> 1;
                    r_d_sh   <= {w_diff, r_d_sh[WIDTH-1:1]};
                    r_borrow <= w_borrow_nxt;
                    r_cnt    <= r_cnt + 1'b1;
                    if (r_cnt == c_LAST) begin
                        // Last cell evaluates the sign bit, so its diff is the result MSB.
                        r_bout  <= w_borrow_nxt;
                        r_ovf   <= (r_a_msb != r_b_msb) & (w_diff != r_a_msb);
                        r_state <= S_DONE;
                    end
                end
                S_DONE: begin
                    if (out_ready) begin
                        r_state <= S_IDLE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_serial_subtractor.sv
// ============================================================================
//  Module   : tb_serial_subtractor
//  Purpose  : Directed self-checking bench for serial_subtractor (WIDTH=4).
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_serial_subtractor;

    localparam int c_WIDTH = 4;

    logic               clk;
    logic               rst_n;
    logic               ena;
    logic               in_valid;
    logic               in_ready;
    logic [c_WIDTH-1:0] a;
    logic [c_WIDTH-1:0] b;
    logic               out_valid;
    logic               out_ready;
    logic [c_WIDTH-1:0] d;
    logic               bout;
    logic               ovf;

    int n_total;
    int n_bad;
    int rdy_low;

    serial_subtractor #(.WIDTH(c_WIDTH)) u_dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .ena       (ena),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .d         (d),
        .bout      (bout),
        .ovf       (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic start_op(input logic [c_WIDTH-1:0] av, input logic [c_WIDTH-1:0] bv);
        a        = av;
        b        = bv;
        in_valid = 1'b1;
        #1;
        chk("accept_ready", in_ready, 1);
        step();
        in_valid = 1'b0;
        a        = c_WIDTH'($urandom);
        b        = c_WIDTH'($urandom);
    endtask

    task automatic wait_done(input int exp_lat);
        int lat;
        lat     = 0;
        rdy_low = 0;
        while (!out_valid && lat < 40) begin
            if (!in_ready) rdy_low++;
            step();
            lat++;
        end
        if (!in_ready) rdy_low++;
        chk("latency", lat, exp_lat);
    endtask

    task automatic chk_res(input logic [c_WIDTH-1:0] dv, input logic bo, input logic ov);
        chk("out_valid", out_valid, 1);
        chk("in_ready_done", in_ready, 0);
        chk("d", d, dv);
        chk("bout", bout, bo);
        chk("ovf", ovf, ov);
    endtask

    task automatic run_op(input logic [c_WIDTH-1:0] av, input logic [c_WIDTH-1:0] bv,
                          input logic [c_WIDTH-1:0] dv, input logic bo, input logic ov);
        out_ready = 1'b1;
        start_op(av, bv);
        wait_done(c_WIDTH);
        chk_res(dv, bo, ov);
        step();
        chk("release_ready", in_ready, 1);
        chk("release_valid", out_valid, 0);
    endtask

    initial begin
        int seen;
        n_total   = 0;
        n_bad     = 0;
        rst_n     = 1'b0;
        ena       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        a         = '0;
        b         = '0;

        #1;
        chk("rst_in_ready", in_ready, 0);
        chk("rst_out_valid", out_valid, 0);
        step();
        step();
        chk("rst_d", d, 0);
        chk("rst_bout", bout, 0);
        chk("rst_ovf", ovf, 0);
        rst_n = 1'b1;
        #1;
        chk("post_rst_ready", in_ready, 1);

        // -7 - 3 = -10 does not fit in 4-bit signed, so ovf is set.
        run_op(4'd9, 4'd3, 4'd6, 1'b0, 1'b1);
        chk("in_ready_low_cycles", rdy_low, 5);
        run_op(4'd3, 4'd9, 4'hA, 1'b1, 1'b1);
        run_op(4'd5, 4'd5, 4'h0, 1'b0, 1'b0);
        run_op(4'd8, 4'd1, 4'h7, 1'b0, 1'b1);
        run_op(4'd0, 4'd1, 4'hF, 1'b1, 1'b0);

        // Reset lands on the second SHIFT edge.
        start_op(4'd15, 4'd1);
        step();
        rst_n = 1'b0;
        #1;
        chk("midrst_in_ready", in_ready, 0);
        chk("midrst_out_valid", out_valid, 0);
        step();
        chk("midrst_d", d, 0);
        chk("midrst_bout", bout, 0);
        chk("midrst_ovf", ovf, 0);
        rst_n = 1'b1;
        #1;
        chk("midrst_idle", in_ready, 1);
        seen = 0;
        for (int i = 0; i < 8; i++) begin
            if (out_valid) seen++;
            step();
        end
        chk("midrst_no_result", seen, 0);
        run_op(4'd6, 4'd6, 4'h0, 1'b0, 1'b0);

        // Backpressure with an ignored operand pulse.
        out_ready = 1'b0;
        start_op(4'd12, 4'd4);
        wait_done(c_WIDTH);
        chk_res(4'd8, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            a        = 4'd1;
            b        = 4'd1;
            in_valid = 1'b1;
            #1;
            chk("bp_valid", out_valid, 1);
            chk("bp_ready", in_ready, 0);
            chk("bp_d", d, 8);
            step();
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        step();
        chk("bp_release_valid", out_valid, 0);
        chk("bp_release_ready", in_ready, 1);
        seen = 0;
        for (int i = 0; i < 8; i++) begin
            if (out_valid) seen++;
            step();
        end
        chk("bp_ignored_no_result", seen, 0);
        chk("bp_d_held", d, 8);

        // Two ena-low cycles in the middle of SHIFT.
        out_ready = 1'b0;
        start_op(4'd7, 4'd2);
        step();
        step();
        ena = 1'b0;
        #1;
        chk("ena0_in_ready", in_ready, 0);
        chk("ena0_out_valid", out_valid, 0);
        step();
        step();
        ena = 1'b1;
        #1;
        wait_done(2);
        chk_res(4'd5, 1'b0, 1'b0);
        ena = 1'b0;
        #1;
        chk("ena0_done_valid", out_valid, 0);
        step();
        ena = 1'b1;
        #1;
        chk("ena1_done_valid", out_valid, 1);
        chk("ena_d", d, 5);
        out_ready = 1'b1;
        step();
        chk("ena_release_ready", in_ready, 1);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule

`default_nettype wire
